// File: rtl/wb_master_port.sv
// Wishbone B4 classic single-beat initiator: turns client requests into one
// bus cycle and hands back read data or an error through a response channel.
module wb_master_port #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [3:0]  req_sel_i,
   input  logic [31:0] req_adr_i,
   input  logic [31:0] req_dat_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_dat_o,
   output logic        rsp_err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t          state;
   logic [TO_W-1:0] to_cnt;

   assign req_ready_o = (state == IDLE);
   assign busy_o      = (state != IDLE);

   // Bus-side fields stay put while idle; only cyc/stb qualify a transfer.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         to_cnt      <= '0;
         wbm_cyc_o   <= 1'b0;
         wbm_stb_o   <= 1'b0;
         wbm_we_o    <= 1'b0;
         wbm_sel_o   <= 4'h0;
         wbm_adr_o   <= 32'h0;
         wbm_dat_o   <= 32'h0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_dat_o   <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  wbm_we_o  <= req_we_i;
                  wbm_sel_o <= req_sel_i;
                  wbm_adr_o <= req_adr_i;
                  wbm_dat_o <= req_dat_i;
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  to_cnt    <= '0;
                  state     <= BUS;
               end
            end
            BUS: begin
               to_cnt <= to_cnt + 1'b1;
               // Slave error beats ack, and an ack in the last allowed cycle still completes.
               if (wbm_err_i) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_err_o   <= 1'b1;
                  rsp_dat_o   <= 32'h0;
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
               end else if (wbm_ack_i) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_err_o   <= 1'b0;
                  rsp_dat_o   <= wbm_we_o ? 32'h0 : wbm_dat_i;
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
               end else if (to_cnt == TO_LAST) begin
                  wbm_cyc_o   <= 1'b0;
                  wbm_stb_o   <= 1'b0;
                  rsp_err_o   <= 1'b1;
                  rsp_dat_o   <= 32'h0;
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_master_port.sv
// Directed bench for wb_master_port with TIMEOUT=4 and a scriptable slave
// whose ack is either combinational from stb or driven step by step.
module tb_wb_master_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [3:0]  req_sel;
   logic [31:0] req_adr;
   logic [31:0] req_dat;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        wbm_cyc;
   logic        wbm_stb;
   logic        wbm_we;
   logic [3:0]  wbm_sel;
   logic [31:0] wbm_adr;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack;
   logic        wbm_err;
   logic        busy;

   logic        ack_comb;
   logic        ack_drv;
   int          checks = 0;
   int          errors = 0;

   assign wbm_ack = ack_comb ? (wbm_cyc & wbm_stb) : ack_drv;

   always #5 clk = ~clk;

   wb_master_port #(.TIMEOUT(4), .TO_W(16)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_sel_i   (req_sel),
      .req_adr_i   (req_adr),
      .req_dat_i   (req_dat),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_dat_o   (rsp_dat),
      .rsp_err_o   (rsp_err),
      .wbm_cyc_o   (wbm_cyc),
      .wbm_stb_o   (wbm_stb),
      .wbm_we_o    (wbm_we),
      .wbm_sel_o   (wbm_sel),
      .wbm_adr_o   (wbm_adr),
      .wbm_dat_o   (wbm_dat_o),
      .wbm_dat_i   (wbm_dat_i),
      .wbm_ack_i   (wbm_ack),
      .wbm_err_i   (wbm_err),
      .busy_o      (busy)
   );

   // Advance one clock and settle just past the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic we, input logic [3:0] sel,
                                input logic [31:0] adr, input logic [31:0] dat);
      req_valid = v;
      req_we    = we;
      req_sel   = sel;
      req_adr   = adr;
      req_dat   = dat;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b1; rsp_ready = 1'b0; wbm_dat_i = 32'h0; wbm_err = 1'b0;
      ack_comb = 1'b0; ack_drv = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      tick(); tick();
      checkOutput("rst_cyc", {31'b0, wbm_cyc}, 32'd0);
      checkOutput("rst_stb", {31'b0, wbm_stb}, 32'd0);
      checkOutput("rst_adr", wbm_adr, 32'h0);
      checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      rst = 1'b0;
      tick();
      checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);

      $display("[TB] write with combinational ack");
      ack_comb = 1'b1;
      applyStimulus(1'b1, 1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput("wr_cyc", {31'b0, wbm_cyc}, 32'd1);
      checkOutput("wr_stb", {31'b0, wbm_stb}, 32'd1);
      checkOutput("wr_we", {31'b0, wbm_we}, 32'd1);
      checkOutput("wr_adr", wbm_adr, 32'h3000_0004);
      checkOutput("wr_dat", wbm_dat_o, 32'hDEAD_BEEF);
      checkOutput("wr_sel", {28'b0, wbm_sel}, 32'hF);
      checkOutput("wr_busy", {31'b0, busy}, 32'd1);
      checkOutput("wr_req_ready", {31'b0, req_ready}, 32'd0);
      tick();
      checkOutput("wr_cyc_drop", {31'b0, wbm_cyc}, 32'd0);
      checkOutput("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("wr_rsp_err", {31'b0, rsp_err}, 32'd0);
      checkOutput("wr_rsp_dat", rsp_dat, 32'h0);
      checkOutput("wr_adr_hold", wbm_adr, 32'h3000_0004);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("wr_rsp_done", {31'b0, rsp_valid}, 32'd0);
      checkOutput("wr_idle_ready", {31'b0, req_ready}, 32'd1);

      $display("[TB] read with 3 wait states");
      ack_comb = 1'b0;
      wbm_dat_i = 32'h1234_5678;
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h3000_0008, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         checkOutput($sformatf("rd_stb_%0d", i), {31'b0, wbm_stb}, 32'd1);
         if (i == 4) ack_drv = 1'b1;
         if (i < 4) checkOutput($sformatf("rd_no_rsp_%0d", i), {31'b0, rsp_valid}, 32'd0);
         tick();
      end
      ack_drv = 1'b0;
      wbm_dat_i = 32'h0;
      checkOutput("rd_stb_drop", {31'b0, wbm_stb}, 32'd0);
      checkOutput("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("rd_rsp_dat", rsp_dat, 32'h1234_5678);
      checkOutput("rd_rsp_err", {31'b0, rsp_err}, 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      $display("[TB] timeout with silent slave");
      wbm_dat_i = 32'hCAFE_F00D;
      applyStimulus(1'b1, 1'b0, 4'h3, 32'h3000_0010, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         checkOutput($sformatf("to_stb_%0d", i), {31'b0, wbm_stb}, 32'd1);
         tick();
      end
      checkOutput("to_stb_drop", {31'b0, wbm_stb}, 32'd0);
      checkOutput("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("to_rsp_err", {31'b0, rsp_err}, 32'd1);
      checkOutput("to_rsp_dat", rsp_dat, 32'h0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      $display("[TB] ack in the final timeout cycle");
      applyStimulus(1'b1, 1'b1, 4'hF, 32'h3000_0014, 32'h0000_0055);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      tick(); tick(); tick();
      checkOutput("late_stb_4", {31'b0, wbm_stb}, 32'd1);
      ack_drv = 1'b1;
      tick();
      ack_drv = 1'b0;
      checkOutput("late_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("late_rsp_err", {31'b0, rsp_err}, 32'd0);
      checkOutput("late_rsp_dat", rsp_dat, 32'h0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      $display("[TB] ack and err together");
      wbm_dat_i = 32'h7777_7777;
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h3000_0018, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      ack_drv = 1'b1; wbm_err = 1'b1;
      tick();
      ack_drv = 1'b0; wbm_err = 1'b0;
      checkOutput("ae_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("ae_rsp_err", {31'b0, rsp_err}, 32'd1);
      checkOutput("ae_rsp_dat", rsp_dat, 32'h0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      $display("[TB] stray ack while idle");
      ack_drv = 1'b1;
      tick();
      ack_drv = 1'b0;
      tick();
      checkOutput("stray_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      checkOutput("stray_busy", {31'b0, busy}, 32'd0);
      checkOutput("stray_cyc", {31'b0, wbm_cyc}, 32'd0);

      $display("[TB] response backpressure");
      ack_comb = 1'b1;
      wbm_dat_i = 32'hAABB_CCDD;
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h3000_0020, 32'h0);
      tick();
      applyStimulus(1'b1, 1'b1, 4'h1, 32'h3000_0024, 32'h0000_00A5);
      tick();
      wbm_dat_i = 32'h0;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("bp_valid_%0d", i), {31'b0, rsp_valid}, 32'd1);
         checkOutput($sformatf("bp_dat_%0d", i), rsp_dat, 32'hAABB_CCDD);
         checkOutput($sformatf("bp_ready_%0d", i), {31'b0, req_ready}, 32'd0);
         checkOutput($sformatf("bp_cyc_%0d", i), {31'b0, wbm_cyc}, 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("bp_rsp_done", {31'b0, rsp_valid}, 32'd0);
      checkOutput("bp_not_accepted", {31'b0, wbm_cyc}, 32'd0);
      checkOutput("bp_idle_ready", {31'b0, req_ready}, 32'd1);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput("bp_next_cyc", {31'b0, wbm_cyc}, 32'd1);
      checkOutput("bp_next_adr", wbm_adr, 32'h3000_0024);
      checkOutput("bp_next_sel", {28'b0, wbm_sel}, 32'h1);
      tick();
      checkOutput("bp_next_rsp", {31'b0, rsp_valid}, 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      $display("[TB] reset during bus phase");
      ack_comb = 1'b0;
      applyStimulus(1'b1, 1'b0, 4'hF, 32'h3000_0030, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput("mr_stb_before", {31'b0, wbm_stb}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("mr_cyc", {31'b0, wbm_cyc}, 32'd0);
      checkOutput("mr_stb", {31'b0, wbm_stb}, 32'd0);
      checkOutput("mr_req_ready", {31'b0, req_ready}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("mr_no_rsp_%0d", i), {31'b0, rsp_valid}, 32'd0);
         tick();
      end
      ack_comb = 1'b1;
      applyStimulus(1'b1, 1'b1, 4'hC, 32'h3000_0040, 32'h0BAD_F00D);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      checkOutput("mr_next_stb", {31'b0, wbm_stb}, 32'd1);
      checkOutput("mr_next_dat", wbm_dat_o, 32'h0BAD_F00D);
      tick();
      checkOutput("mr_next_rsp", {31'b0, rsp_valid}, 32'd1);
      checkOutput("mr_next_err", {31'b0, rsp_err}, 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("mr_final_idle", {31'b0, busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
